hazard_ctrl: RTL and testbench

Pipeline hazard controller that sequences fetch/decode/execute register writes around the forwarding units. It handles the hazards that forwarding cannot cover:

- load-use stalls
- multi-cycle flushes after a taken branch/jump
- freezes while data memory is not ready

It also handles `hlt`, with a memory-timeout error. It sits beside the forwarding muxes and drives the PC, IF/ID and ID/EX enables; it uses the shared opcode definitions (`lw`, `hlt`).

---
 rtl/hazard_if.sv | 31 +++
 rtl/hazard_ctrl.sv | 71 +++++++
 tb/tb_hazard_ctrl.sv | 171 +++++++++++++++++
 3 files changed

// File: rtl/hazard_if.sv
// hazard_if: pipeline-side hazard inputs and the controller's enable/status outputs.
interface hazard_if #(parameter int CNT_W = 32);
  logic [4:0]       if_id_rs1;
  logic [4:0]       if_id_rs2;
  logic             if_id_uses_rs2;
  logic [6:0]       id_ex_opcode;
  logic [4:0]       id_ex_rd;
  logic             ex_branch_taken;
  logic             mem_req;
  logic             mem_ready;
  logic             pc_write;
  logic             if_id_write;
  logic             if_id_flush;
  logic             id_ex_bubble;
  logic             freeze;
  logic             halted;
  logic             mem_err;
  logic [CNT_W-1:0] stall_count;
  modport master(
    output if_id_rs1, if_id_rs2, if_id_uses_rs2, id_ex_opcode, id_ex_rd,
           ex_branch_taken, mem_req, mem_ready,
    input  pc_write, if_id_write, if_id_flush, id_ex_bubble, freeze,
           halted, mem_err, stall_count
  );
  modport slave(
    input  if_id_rs1, if_id_rs2, if_id_uses_rs2, id_ex_opcode, id_ex_rd,
           ex_branch_taken, mem_req, mem_ready,
    output pc_write, if_id_write, if_id_flush, id_ex_bubble, freeze,
           halted, mem_err, stall_count
  );
endinterface

// File: rtl/hazard_ctrl.sv
// hazard_ctrl: load-use stalls, branch flushes, memory freezes and halt with memory timeout.
module hazard_ctrl #(
    parameter int FLUSH_CYCLES = 2,
    parameter int MEM_TIMEOUT  = 255,
    parameter int CNT_W        = 32
) (
    input logic clk,
    input logic rst,
    hazard_if.slave h
);
    localparam logic [6:0] OP_LW  = 7'b0000011;
    localparam logic [6:0] OP_HLT = 7'b1111111;
    typedef enum logic [1:0] {RUN, FLUSH, HALT} state_t;
    state_t           state;
    logic [3:0]       flush_cnt;
    logic [15:0]      wait_cnt;
    logic             mem_err_q;
    logic [CNT_W-1:0] stall_q;
    logic run, fl, hl, br, is_hlt, memwait, loaduse, timeout;
    logic pc_write, if_id_write, if_id_flush, id_ex_bubble, freeze;
    assign run     = state == RUN;
    assign fl      = state == FLUSH;
    assign hl      = state == HALT;
    assign br      = h.ex_branch_taken;
    assign is_hlt  = h.id_ex_opcode == OP_HLT;
    assign memwait = h.mem_req && !h.mem_ready;
    assign loaduse = h.id_ex_opcode == OP_LW && h.id_ex_rd != 5'd0 &&
                     (h.id_ex_rd == h.if_id_rs1 || (h.if_id_uses_rs2 && h.id_ex_rd == h.if_id_rs2));
    assign timeout = memwait && wait_cnt == 16'(MEM_TIMEOUT - 1);
    // Reset forces a safe NOP-injecting, PC-holding pattern regardless of state.
    assign freeze       = !rst && memwait;
    assign pc_write     = !rst && !memwait && (fl || (run && (br || !(is_hlt || loaduse))));
    assign if_id_write  = !rst && !memwait && (fl || (run && !br && !is_hlt && !loaduse));
    assign if_id_flush  = rst || (!memwait && (fl || (run && br)));
    assign id_ex_bubble = rst || hl || (!memwait && (fl || (run && (br || is_hlt || loaduse))));
    assign h.pc_write     = pc_write;
    assign h.if_id_write  = if_id_write;
    assign h.if_id_flush  = if_id_flush;
    assign h.id_ex_bubble = id_ex_bubble;
    assign h.freeze       = freeze;
    assign h.halted       = hl;
    assign h.mem_err      = mem_err_q;
    assign h.stall_count  = stall_q;
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= RUN;
            flush_cnt <= 4'd0;
            wait_cnt  <= 16'd0;
            mem_err_q <= 1'b0;
            stall_q   <= '0;
        end else begin
            wait_cnt <= memwait ? wait_cnt + 16'd1 : 16'd0;
            if (!pc_write && !hl && stall_q != '1) stall_q <= stall_q + 1'b1;
            if (timeout) begin
                mem_err_q <= 1'b1;
                state     <= HALT;
            end else if (!memwait) begin
                // The branch cycle itself is the first flush cycle, so FLUSH lasts FLUSH_CYCLES-1.
                if (run && br && FLUSH_CYCLES > 1) begin
                    state     <= FLUSH;
                    flush_cnt <= 4'(FLUSH_CYCLES - 2);
                end else if (run && !br && is_hlt) begin
                    state <= HALT;
                end else if (fl) begin
                    if (flush_cnt == 4'd0) state <= RUN;
                    else flush_cnt <= flush_cnt - 4'd1;
                end
            end
        end
    end
endmodule

// File: tb/tb_hazard_ctrl.sv
// tb_hazard_ctrl: scoreboard bench comparing hazard_ctrl to a cycle-level behavioural model.
module tb_hazard_ctrl;
    localparam int FC = 3;
    localparam int TO = 5;
    localparam int CW = 4;
    localparam logic [6:0] OP_LW  = 7'b0000011;
    localparam logic [6:0] OP_HLT = 7'b1111111;
    localparam logic [6:0] OP_ADD = 7'b0110011;
    logic clk = 1'b0;
    logic rst = 1'b1;
    hazard_if #(.CNT_W(CW)) h ();
    hazard_ctrl #(.FLUSH_CYCLES(FC), .MEM_TIMEOUT(TO), .CNT_W(CW)) dut (
        .clk(clk),
        .rst(rst),
        .h(h.slave)
    );
    always #5 clk = ~clk;
    typedef struct packed {
        logic          pw, iw, fl, bub, frz, hlt, err;
        logic [CW-1:0] sc;
    } obs_t;
    obs_t q[$];
    int checks = 0;
    int errors = 0;
    // Model state: flush cycles still owed, consecutive wait length, stall total.
    int flush_left = 0;
    int waitc = 0;
    int stalls = 0;
    bit m_halt = 0;
    bit m_err = 0;
    task automatic cycle(input bit r, input bit [4:0] rs1, input bit [4:0] rs2, input bit u2,
                         input bit [6:0] op, input bit [4:0] rd, input bit br,
                         input bit mr, input bit mrdy);
        obs_t e;
        bit mw, lu, go_halt;
        @(posedge clk);
        #1;
        rst = r;
        h.if_id_rs1 = rs1;
        h.if_id_rs2 = rs2;
        h.if_id_uses_rs2 = u2;
        h.id_ex_opcode = op;
        h.id_ex_rd = rd;
        h.ex_branch_taken = br;
        h.mem_req = mr;
        h.mem_ready = mrdy;
        mw = mr && !mrdy;
        lu = op == OP_LW && rd != 0 && (rd == rs1 || (u2 && rd == rs2));
        go_halt = 0;
        e = '0;
        e.hlt = m_halt;
        e.err = m_err;
        e.sc = stalls[CW-1:0];
        if (r) begin
            e = '0;
            e.fl = 1;
            e.bub = 1;
            flush_left = 0;
            waitc = 0;
            stalls = 0;
            m_halt = 0;
            m_err = 0;
        end else begin
            if (m_halt) begin
                e.bub = 1;
                e.frz = mw;
            end else if (mw) e.frz = 1;
            else if (flush_left > 0) begin
                {e.pw, e.iw, e.fl, e.bub} = 4'b1111;
                flush_left--;
            end else if (br) begin
                {e.pw, e.fl, e.bub} = 3'b111;
                flush_left = FC - 1;
            end else if (op == OP_HLT) begin
                e.bub = 1;
                go_halt = 1;
            end else if (lu) e.bub = 1;
            else {e.pw, e.iw} = 2'b11;
            if (!m_halt && !e.pw && stalls < (1 << CW) - 1) stalls++;
            if (mw) begin
                if (waitc == TO - 1) begin
                    m_err = 1;
                    go_halt = 1;
                end
                waitc++;
            end else waitc = 0;
            if (go_halt) m_halt = 1;
        end
        q.push_back(e);
    endtask
    task automatic idle();
        cycle(0, 5'd1, 5'd2, 0, OP_ADD, 5'd3, 0, 0, 1);
    endtask
    always @(negedge clk) begin
        obs_t e, a;
        if (q.size() > 0) begin
            e = q.pop_front();
            a = {h.pc_write, h.if_id_write, h.if_id_flush, h.id_ex_bubble, h.freeze,
                 h.halted, h.mem_err, h.stall_count};
            checks++;
            if (a !== e) begin
                errors++;
                $display("FAIL outputs t=%0t {pw,iw,fl,bub,frz,hlt,err,sc}: got %b required %b",
                         $time, a, e);
            end
        end
    end
    initial begin
        int hold;
        h.if_id_rs1 = 0;
        h.if_id_rs2 = 0;
        h.if_id_uses_rs2 = 0;
        h.id_ex_opcode = 0;
        h.id_ex_rd = 0;
        h.ex_branch_taken = 0;
        h.mem_req = 0;
        h.mem_ready = 1;
        repeat (2) cycle(1, 5'd5, 5'd5, 1, OP_LW, 5'd5, 1, 1, 0);
        idle();
        cycle(0, 5'd5, 5'd0, 0, OP_LW, 5'd5, 0, 0, 1);
        idle();
        cycle(0, 5'd0, 5'd0, 0, OP_LW, 5'd0, 0, 0, 1);
        cycle(0, 5'd1, 5'd7, 1, OP_LW, 5'd7, 0, 0, 1);
        cycle(0, 5'd1, 5'd7, 0, OP_LW, 5'd7, 0, 0, 1);
        cycle(0, 5'd1, 5'd2, 0, OP_ADD, 5'd3, 1, 0, 1);
        repeat (4) idle();
        cycle(0, 5'd1, 5'd2, 0, OP_ADD, 5'd3, 1, 1, 0);
        cycle(0, 5'd1, 5'd2, 0, OP_ADD, 5'd3, 1, 0, 1);
        cycle(0, 5'd1, 5'd2, 0, OP_ADD, 5'd3, 0, 1, 0);
        repeat (3) cycle(0, 5'd1, 5'd2, 0, OP_ADD, 5'd3, 0, 1, 0);
        repeat (4) idle();
        cycle(0, 5'd4, 5'd4, 1, OP_HLT, 5'd4, 0, 0, 1);
        for (int i = 0; i < 6; i++)
            cycle(0, 5'(i), 5'(i), 1, OP_LW, 5'(i), i[0], i[1], i[2]);
        cycle(1, 5'd1, 5'd2, 0, OP_ADD, 5'd3, 0, 0, 1);
        cycle(0, 5'd4, 5'd4, 1, OP_HLT, 5'd4, 0, 0, 1);
        cycle(1, 5'd1, 5'd2, 0, OP_ADD, 5'd3, 0, 0, 1);
        repeat (TO + 2) cycle(0, 5'd1, 5'd2, 0, OP_ADD, 5'd3, 0, 1, 0);
        cycle(1, 5'd1, 5'd2, 0, OP_ADD, 5'd3, 0, 0, 1);
        repeat (TO - 1) cycle(0, 5'd1, 5'd2, 0, OP_ADD, 5'd3, 0, 1, 0);
        idle();
        repeat (TO - 1) cycle(0, 5'd1, 5'd2, 0, OP_ADD, 5'd3, 0, 1, 0);
        idle();
        repeat (20) cycle(0, 5'd6, 5'd0, 0, OP_LW, 5'd6, 0, 0, 1);
        idle();
        cycle(1, 5'd1, 5'd2, 0, OP_ADD, 5'd3, 0, 0, 1);
        hold = 0;
        for (int n = 0; n < 4000; n++) begin
            bit r, mr;
            bit [6:0] op;
            int p;
            hold = m_halt ? hold + 1 : 0;
            r = hold > 6 || $urandom_range(0, 99) < 2;
            p = $urandom_range(0, 99);
            op = p < 40 ? OP_LW : p < 43 ? OP_HLT : OP_ADD;
            mr = $urandom_range(0, 99) < 30;
            cycle(r, 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)), 1'($urandom),
                  op, 5'($urandom_range(0, 7)), $urandom_range(0, 99) < 15,
                  mr, $urandom_range(0, 99) < 60);
        end
        @(posedge clk);
        @(posedge clk);
        checks++;
        if (q.size() != 0) begin
            errors++;
            $display("FAIL drain: %0d entries left, required 0", q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
